imm_narrower: RTL and testbench
===============================

# imm_narrower

Narrowing counterpart of the 24→32-bit immediate sign extender. It takes 32-bit datapath values and packs each one into a 24-bit immediate field. For every item it checks whether the value is representable in the selected (signed or unsigned) 24-bit range, then either truncates or saturates it. It sits between the ALU/result path and the instruction or immediate encoder, behind a valid/ready handshake with a 2-entry skid buffer, and keeps a saturating count of overflow events.

## Interface
Parameters:
- IN_W, 32, input data width
- OUT_W, 24, packed field width (IN_W > OUT_W)
- CNT_W, 16, overflow counter width

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream item present
- in_ready  out  1  block can accept an item this cycle
- in_data  in  IN_W  value to narrow
- signop  in  1  1 = signed range check/saturation, 0 = unsigned; sampled with in_data
- sat_en  in  1  1 = saturate on overflow, 0 = truncate; sampled with in_data
- out_valid  out  1  packed item present
- out_ready  in  1  downstream accepts
- out_data  out  OUT_W  packed field
- out_ovf  out  1  item was not representable (qualified by out_valid)
- ovf_count  out  CNT_W  saturating count of accepted overflowed items
- clr_count  in  1  synchronous clear of ovf_count

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Overflow detection:
  - Signed: ovf = in_data[IN_W-1:OUT_W-1] not all equal.
  - Unsigned: ovf = in_data[IN_W-1:OUT_W] != 0.
- Output data:
  - ovf=0: out_data = in_data[OUT_W-1:0].
  - ovf=1, sat_en=0: out_data = in_data[OUT_W-1:0] (truncated); out_ovf still 1.
  - ovf=1, sat_en=1, signed: 0x7FFFFF if in_data[31]=0, else 0x800000.
  - ovf=1, sat_en=1, unsigned: 0xFFFFFF.
- Result is computed at input acceptance and stored as {data, ovf}. No combinational path from in_data to out_data.
- Buffer state machine, with main register M driving the outputs and skid register S:
  - EMPTY: out_valid=0, in_ready=1. Input transfer → ONE (item to M).
  - ONE: out_valid=1, in_ready=1.
    - Input transfer and output transfer together: new item to M, stay ONE.
    - Input transfer only: new item to S → TWO.
    - Output transfer only → EMPTY.
  - TWO: out_valid=1, in_ready=0.
    - Output transfer: S moves to M → ONE.
    - No output transfer: hold.
- in_ready is a register output: it is 1 exactly when S is empty, with no combinational dependence on out_ready.
- Ordering: items leave in acceptance order. No item is dropped or duplicated.
- Counter:
  - Increments by 1 on each input transfer with ovf=1.
  - Holds at 2^CNT_W-1.
  - clr_count=1 sets it to 0. When clear and increment coincide, clear wins and the count is 0.
- While out_valid=1 and out_ready=0, out_data and out_ovf hold stable.

## Timing
- Latency: an item accepted at edge N is visible on out_data/out_valid after edge N, so it can transfer at edge N+1.
- Throughput: 1 item/cycle when out_ready is held high.
- Reset: the first rising edge with reset=1 puts the block in EMPTY, with:
  - in_ready=1, out_valid=0
  - out_data=0, out_ovf=0
  - ovf_count=0
- While reset=1, no input transfer takes effect and the counter does not increment.
- Reset during an in-flight transfer discards both buffered items. No partial state survives.
- in_ready deasserts on the edge S fills and reasserts on the edge S drains.

## Test plan
- Signed, sat_en=1, out_ready=1, values applied back-to-back:
  - 0x00400000 → out_data 0x400000, out_ovf 0.
  - 0x00800000 → out_data 0x7FFFFF, out_ovf 1.
  - 0xFFFFFFFF → out_data 0xFFFFFF, out_ovf 0.
  - 0xFF000000 → out_data 0x800000, out_ovf 1.
  - Final ovf_count = 2, one item out per cycle, latency 1.
- Unsigned path:
  - 0x00800000 → out_data 0x800000, out_ovf 0.
  - 0x01000000 with sat_en=1 → out_data 0xFFFFFF, out_ovf 1.
  - 0x01000000 with sat_en=0 → out_data 0x000000, out_ovf 1.
- Backpressure:
  - Hold out_ready=0 and push A, B, C. A and B are accepted; in_ready drops after B; C is held upstream.
  - Raise out_ready. Outputs appear in order A, B, C with no gaps or loss, and out_data is stable while stalled.
- Counter:
  - CNT_W=4: 20 overflowed items → ovf_count holds at 15.
  - Assert clr_count on the same cycle as an overflowed acceptance → ovf_count = 0.
- Reset mid-stream:
  - State TWO with out_ready=0; assert reset for 1 cycle → out_valid 0, in_ready 1, ovf_count 0.
  - Next item accepted after reset emerges alone and correct.
- Randomized valid/ready toggling against a reference model of the range check and saturation:
  - 10k items, in-order match, ovf_count equal to the model's count.

Source files
------------

// File: rtl/imm_narrower.sv
// rtl/imm_narrower.sv - 32-to-24-bit immediate narrower with range check, saturation, skid buffer and overflow counter
module imm_narrower #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             signop,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_count
);

  localparam logic [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] UMAX = {OUT_W{1'b1}};
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state;
  logic [OUT_W-1:0] m_data;
  logic             m_ovf;
  logic [OUT_W-1:0] s_data;
  logic             s_ovf;

  logic [IN_W-OUT_W:0] sign_field;
  logic                sgn_ovf;
  logic                uns_ovf;
  logic                nv_ovf;
  logic [OUT_W-1:0]    nv_data;
  logic                in_xfer;
  logic                out_xfer;

  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid && out_ready;
  assign sign_field = in_data[IN_W-1:OUT_W-1];
  // Signed fits only when the dropped bits all copy the new sign bit.
  assign sgn_ovf    = !((&sign_field) || !(|sign_field));
  assign uns_ovf    = |in_data[IN_W-1:OUT_W];
  assign out_data   = m_data;
  assign out_ovf    = m_ovf;

  // Narrowed value of the incoming item; only ever captured into M or S.
  always_comb begin
    nv_ovf  = signop ? sgn_ovf : uns_ovf;
    nv_data = in_data[OUT_W-1:0];
    if (nv_ovf && sat_en) begin
      if (signop) nv_data = in_data[IN_W-1] ? SMIN : SMAX;
      else        nv_data = UMAX;
    end
  end

  // Two-entry skid buffer: M drives the outputs, S catches the item accepted while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      m_data    <= '0;
      m_ovf     <= 1'b0;
      s_data    <= '0;
      s_ovf     <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            m_data    <= nv_data;
            m_ovf     <= nv_ovf;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            m_data <= nv_data;
            m_ovf  <= nv_ovf;
          end else if (in_xfer) begin
            s_data   <= nv_data;
            s_ovf    <= nv_ovf;
            in_ready <= 1'b0;
            state    <= TWO;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            m_data   <= s_data;
            m_ovf    <= s_ovf;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Saturating overflow counter; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || clr_count) begin
      ovf_count <= '0;
    end else if (in_xfer && nv_ovf && ovf_count != CMAX) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_narrower.sv
// tb/tb_imm_narrower.sv - self-checking bench for imm_narrower
module tb_imm_narrower;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready, in_ready4;
  logic [31:0] in_data;
  logic        signop;
  logic        sat_en;
  logic        out_valid, out_valid4;
  logic        out_ready;
  logic [23:0] out_data, out_data4;
  logic        out_ovf, out_ovf4;
  logic [15:0] ovf_count;
  logic [3:0]  ovf_count4;
  logic        clr_count;

  int nvec = 0;
  int nerr = 0;

  logic [24:0] q[$];
  int          mcnt16 = 0;
  int          mcnt4  = 0;

  always #5 clk = ~clk;

  imm_narrower dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .signop(signop), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .ovf_count(ovf_count), .clr_count(clr_count)
  );

  imm_narrower #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .signop(signop), .sat_en(sat_en),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_ovf(out_ovf4), .ovf_count(ovf_count4), .clr_count(clr_count)
  );

  // Reference: {field, ovf} from the numeric value and the representable range.
  function automatic logic [24:0] narrow(input logic [31:0] d, input logic sg, input logic sat);
    longint v;
    logic ovf;
    logic [23:0] o;
    if (sg) begin
      v   = longint'($signed(d));
      ovf = (v > 64'sd8388607) || (v < -64'sd8388608);
    end else begin
      v   = longint'({32'd0, d});
      ovf = v > 64'sd16777215;
    end
    o = d[23:0];
    if (ovf && sat) o = sg ? ((v < 0) ? 24'h800000 : 24'h7FFFFF) : 24'hFFFFFF;
    return {o, ovf};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Compare process: outputs against the queue model every cycle, then advance the model.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      mcnt16 = 0;
      mcnt4  = 0;
    end else begin
      chk("mon_out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("mon_in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (out_valid && q.size() > 0) begin
        chk("mon_out_data", 32'(out_data), 32'(q[0][24:1]));
        chk("mon_out_ovf", 32'(out_ovf), 32'(q[0][0]));
      end
      chk("mon_count16", 32'(ovf_count), 32'(mcnt16));
      chk("mon_count4", 32'(ovf_count4), 32'(mcnt4));
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        logic [24:0] r;
        r = narrow(in_data, signop, sat_en);
        q.push_back(r);
        if (r[0]) begin
          if (mcnt16 < 65535) mcnt16++;
          if (mcnt4 < 15) mcnt4++;
        end
      end
      if (clr_count) begin
        mcnt16 = 0;
        mcnt4  = 0;
      end
    end
  end

  logic [31:0] sv_in [4] = '{32'h00400000, 32'h00800000, 32'hFFFFFFFF, 32'hFF000000};
  logic [23:0] sv_out[4] = '{24'h400000, 24'h7FFFFF, 24'hFFFFFF, 24'h800000};
  logic        sv_ovf[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] uv_in [3] = '{32'h00800000, 32'h01000000, 32'h01000000};
  logic        uv_sat[3] = '{1'b1, 1'b1, 1'b0};
  logic [23:0] uv_out[3] = '{24'h800000, 24'hFFFFFF, 24'h000000};
  logic        uv_ovf[3] = '{1'b0, 1'b1, 1'b1};
  logic [31:0] edges [8] = '{32'h007FFFFF, 32'h00800000, 32'hFF800000, 32'hFF7FFFFF,
                             32'h00FFFFFF, 32'h01000000, 32'h80000000, 32'h7FFFFFFF};

  initial begin
    logic [24:0] r;
    int accepted;
    int cycles;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; signop = 1'b1; sat_en = 1'b1;
    out_ready = 1'b0; clr_count = 1'b0;

    // Pin the model with hand-computed values.
    r = narrow(32'h00800000, 1'b1, 1'b1); chk("model_s_pos", 32'(r), 32'({24'h7FFFFF, 1'b1}));
    r = narrow(32'hFF800000, 1'b1, 1'b1); chk("model_s_min", 32'(r), 32'({24'h800000, 1'b0}));
    r = narrow(32'h01000000, 1'b0, 1'b0); chk("model_u_trunc", 32'(r), 32'({24'h000000, 1'b1}));
    r = narrow(32'h00FFFFFF, 1'b0, 1'b1); chk("model_u_max", 32'(r), 32'({24'hFFFFFF, 1'b0}));

    tick; tick;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_count", 32'(ovf_count), 32'd0);
    reset = 1'b0;

    // Signed saturating, back-to-back with latency 1.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = sv_in[i];
      tick;
      chk("s_valid", 32'(out_valid), 32'd1);
      chk("s_data", 32'(out_data), 32'(sv_out[i]));
      chk("s_ovf", 32'(out_ovf), 32'(sv_ovf[i]));
    end
    in_valid = 1'b0;
    chk("s_count", 32'(ovf_count), 32'd2);
    tick;
    chk("s_drained", 32'(out_valid), 32'd0);

    // Unsigned path.
    signop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = uv_in[i]; sat_en = uv_sat[i];
      tick;
      chk("u_data", 32'(out_data), 32'(uv_out[i]));
      chk("u_ovf", 32'(out_ovf), 32'(uv_ovf[i]));
    end
    in_valid = 1'b0;
    chk("u_count", 32'(ovf_count), 32'd4);
    clr_count = 1'b1; tick; clr_count = 1'b0;
    chk("clr_count", 32'(ovf_count), 32'd0);

    // Backpressure: A and B buffered, C held upstream.
    signop = 1'b1; sat_en = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h00000AAA; tick;
    chk("bp_a", 32'(out_data), 32'h000AAA);
    in_data = 32'h00000BBB; tick;
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    in_data = 32'h00000CCC;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_stable", 32'(out_data), 32'h000AAA);
      chk("bp_hold", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1; tick;
    chk("bp_b", 32'(out_data), 32'h000BBB);
    chk("bp_ready_up", 32'(in_ready), 32'd1);
    tick;
    chk("bp_c", 32'(out_data), 32'h000CCC);
    in_valid = 1'b0; tick;
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Counter saturation and clear-wins.
    signop = 1'b0; in_data = 32'h10000000; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick;
    in_valid = 1'b0;
    chk("cnt4_sat", 32'(ovf_count4), 32'd15);
    chk("cnt16_20", 32'(ovf_count), 32'd20);
    in_valid = 1'b1; clr_count = 1'b1; tick;
    in_valid = 1'b0; clr_count = 1'b0;
    chk("clr_wins16", 32'(ovf_count), 32'd0);
    chk("clr_wins4", 32'(ovf_count4), 32'd0);
    tick;

    // Reset while in TWO.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h01000000; tick; tick;
    in_valid = 1'b0;
    chk("two_ready", 32'(in_ready), 32'd0);
    chk("two_count", 32'(ovf_count), 32'd2);
    reset = 1'b1; tick; reset = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_count", 32'(ovf_count), 32'd0);
    signop = 1'b1; in_valid = 1'b1; in_data = 32'h00000123; tick;
    in_valid = 1'b0; out_ready = 1'b1;
    chk("post_rst_data", 32'(out_data), 32'h000123);
    chk("post_rst_ovf", 32'(out_ovf), 32'd0);
    tick;
    chk("post_rst_alone", 32'(out_valid), 32'd0);

    // Random valid/ready traffic against the model.
    accepted = 0; cycles = 0;
    while (accepted < 10000 && cycles < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_count = ($urandom_range(0, 63) == 0);
      signop    = $urandom_range(0, 1);
      sat_en    = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: in_data = $urandom;
        1: in_data = {{8{1'b0}}, 24'($urandom)} ^ {32{$urandom_range(0, 1) == 1}};
        2: in_data = edges[$urandom_range(0, 7)];
        default: in_data = 32'($urandom_range(0, 255)) << $urandom_range(16, 31);
      endcase
      if (in_valid && in_ready) accepted++;
      tick;
      cycles++;
    end
    chk("rand_done", 32'(accepted >= 10000), 32'd1);
    in_valid = 1'b0; clr_count = 1'b0; out_ready = 1'b1;
    tick; tick; tick;
    chk("rand_drained", 32'(out_valid), 32'd0);
    chk("rand_count", 32'(ovf_count), 32'(mcnt16));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
